// File: rtl/block_slider.sv
// Moving-block producer: bounces a unit-aligned block, evaluates the player's stop
// against the stored block, and sequences level progression, win and game-over.
module block_slider #(
  parameter int UNIT_LOG2 = 4,
  parameter int COLS      = 20,
  parameter int INIT_SIZE = 4,
  parameter int SPEED_DIV = 2500000,
  parameter int MAX_LEVEL = 12
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic [8:0] prev_block_start,
  input  logic [8:0] prev_block_end,
  input  logic [3:0] prev_block_size,
  output logic [8:0] curr_block_start,
  output logic [8:0] curr_block_end,
  output logic [3:0] curr_block_size,
  output logic       stop_true,
  output logic       intersect_true,
  output logic [3:0] level,
  output logic       game_over,
  output logic       win
);

  localparam int TW = $clog2(SPEED_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(SPEED_DIV - 1);
  localparam logic [6:0]    COLS7    = 7'(COLS);

  typedef enum logic [2:0] {S_LOAD, S_MOVE, S_EVAL, S_COMMIT, S_OVER} state_t;

  state_t        state_q, state_d;
  logic [6:0]    pos_q, pos_d, os_q, os_d;
  logic [3:0]    size_q, size_d, next_size_q, next_size_d, ovl_q, ovl_d;
  logic [3:0]    level_q, level_d, csize_q, csize_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          dir_q, dir_d, go_q, hit_q, hit_d;
  logic [8:0]    start_q, start_d, end_q, end_d;
  logic          stop_q, stop_d, isect_q, isect_d, over_q, over_d, win_q, win_d;

  // The tracker's right edge is implied by start and size, so only those are used.
  logic unused_prev_end;
  assign unused_prev_end = ^prev_block_end;

  function automatic logic [8:0] px(input logic [6:0] u);
    px = 9'({9'b0, u} << UNIT_LOG2);
  endfunction

  logic       go_edge;
  logic [6:0] size7, p7, pe7, ce7, ov_s, ov_e;
  assign go_edge = go && !go_q;
  assign size7   = 7'(size_q);
  assign p7      = 7'(prev_block_start >> UNIT_LOG2);
  assign pe7     = p7 + 7'(prev_block_size) - 7'd1;
  assign ce7     = pos_q + size7 - 7'd1;

  always_comb begin
    ov_s = pos_q;
    ov_e = ce7;
    if (prev_block_size != 4'd0) begin
      ov_s = (pos_q > p7) ? pos_q : p7;
      ov_e = (ce7 < pe7) ? ce7 : pe7;
    end
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    size_d      = size_q;
    dir_d       = dir_q;
    tick_d      = tick_q;
    next_size_d = next_size_q;
    os_d        = os_q;
    ovl_d       = ovl_q;
    hit_d       = hit_q;
    level_d     = level_q;
    start_d     = start_q;
    end_d       = end_q;
    csize_d     = csize_q;
    stop_d      = 1'b0;
    isect_d     = 1'b0;
    over_d      = over_q;
    win_d       = win_q;
    case (state_q)
      S_LOAD: begin
        pos_d   = '0;
        dir_d   = 1'b1;
        tick_d  = '0;
        size_d  = next_size_q;
        start_d = '0;
        end_d   = px(7'(next_size_q)) - 9'd1;
        csize_d = next_size_q;
        state_d = S_MOVE;
      end
      S_MOVE: begin
        if (go_edge) begin
          state_d = S_EVAL;
        end else if (tick_q == TICK_MAX) begin
          tick_d = '0;
          // A full-width block has nowhere to go and stays parked at the left edge.
          if (size7 != COLS7) begin
            if (dir_q) begin
              if (pos_q + size7 < COLS7) pos_d = pos_q + 7'd1;
              else begin dir_d = 1'b0; pos_d = pos_q - 7'd1; end
            end else begin
              if (pos_q != 7'd0) pos_d = pos_q - 7'd1;
              else begin dir_d = 1'b1; pos_d = pos_q + 7'd1; end
            end
          end
          start_d = px(pos_d);
          end_d   = px(pos_d + size7) - 9'd1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_EVAL: begin
        os_d    = ov_s;
        ovl_d   = 4'(ov_e - ov_s + 7'd1);
        hit_d   = (ov_s <= ov_e);
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        stop_d  = 1'b1;
        isect_d = hit_q;
        if (hit_q) begin
          start_d     = px(os_q);
          end_d       = px(os_q + 7'(ovl_q)) - 9'd1;
          csize_d     = ovl_q;
          next_size_d = ovl_q;
          level_d     = level_q + 4'd1;
          if (level_q + 4'd1 == 4'(MAX_LEVEL)) begin
            win_d   = 1'b1;
            over_d  = 1'b1;
            state_d = S_OVER;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          over_d  = 1'b1;
          state_d = S_OVER;
        end
      end
      S_OVER:  state_d = S_OVER;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_LOAD;
      pos_q       <= '0;
      size_q      <= '0;
      dir_q       <= 1'b1;
      tick_q      <= '0;
      next_size_q <= 4'(INIT_SIZE);
      go_q        <= 1'b0;
      os_q        <= '0;
      ovl_q       <= '0;
      hit_q       <= 1'b0;
      level_q     <= '0;
      start_q     <= '0;
      end_q       <= '0;
      csize_q     <= '0;
      stop_q      <= 1'b0;
      isect_q     <= 1'b0;
      over_q      <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      size_q      <= size_d;
      dir_q       <= dir_d;
      tick_q      <= tick_d;
      next_size_q <= next_size_d;
      go_q        <= go;
      os_q        <= os_d;
      ovl_q       <= ovl_d;
      hit_q       <= hit_d;
      level_q     <= level_d;
      start_q     <= start_d;
      end_q       <= end_d;
      csize_q     <= csize_d;
      stop_q      <= stop_d;
      isect_q     <= isect_d;
      over_q      <= over_d;
      win_q       <= win_d;
    end
  end

  assign curr_block_start = start_q;
  assign curr_block_end   = end_q;
  assign curr_block_size  = csize_q;
  assign stop_true        = stop_q;
  assign intersect_true   = isect_q;
  assign level            = level_q;
  assign game_over        = over_q;
  assign win              = win_q;

endmodule

// File: doc/block_slider.md
# block_slider

Producer side of the block-stacking datapath. Generates the moving current block (unit-aligned, bouncing between screen edges), detects the player's stop press, and computes the overlap with the stored previous block. On each stop it presents the trimmed block with a one-cycle stop/intersect strobe so the block tracker can latch it or clear. It also sequences level progression and game-over.

## Interface

Parameters:
- UNIT_LOG2, 4: block unit width is 2^UNIT_LOG2 pixels (16).
- COLS, 20: screen width in units; COLS << UNIT_LOG2 must be ≤ 512.
- INIT_SIZE, 4: starting block size in units, 1..15, ≤ COLS.
- SPEED_DIV, 2500000: clocks per one-unit move, ≥ 2.
- MAX_LEVEL, 12: number of successful stacks that wins the game, 1..15.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- resetn  in  1  reset, synchronous, active-low.
- go  in  1  player stop button as a level; the block edge-detects it internally.
- prev_block_start  in  9  pixel x of the stored block's left edge.
- prev_block_end  in  9  pixel x of the stored block's right edge (inclusive).
- prev_block_size  in  4  stored block size in units; 0 means no previous block.
- curr_block_start  out  9  pixel x of the current block's left edge.
- curr_block_end  out  9  pixel x of the current block's right edge (inclusive).
- curr_block_size  out  4  current block size in units.
- stop_true  out  1  one-cycle strobe marking a stop evaluation.
- intersect_true  out  1  valid with stop_true: the overlap is non-empty.
- level  out  4  count of successful stacks.
- game_over  out  1  sticky; set on a miss or on a win.
- win  out  1  sticky; set when level reaches MAX_LEVEL.

## Operation

Internal state:
- pos: left edge in units.
- size: current size in units.
- dir: 1 = moving right.
- tick: clock divider, 0..SPEED_DIV-1.
- next_size.
- go_q: registered copy of go. A go edge is go && !go_q.

Output encoding, all outputs registered:
- curr_block_start = pos << UNIT_LOG2.
- curr_block_end = ((pos + size) << UNIT_LOG2) - 1.

FSM states:
- **LOAD** (1 cycle): pos=0, dir=1, tick=0, size=next_size. Update the curr_* outputs. Go to MOVE.
- **MOVE**: tick increments each cycle. On tick == SPEED_DIV-1, tick returns to 0 and the block moves:
  - dir=1 and pos+size < COLS: pos+1.
  - dir=1 and pos+size == COLS: dir=0, pos-1.
  - dir=0 and pos > 0: pos-1.
  - dir=0 and pos == 0: dir=1, pos+1.
  - If size == COLS, pos stays 0.
  - The curr_* outputs track pos on the same edge.
  - A go edge goes to EVAL. Movement is suppressed on that cycle, so the block freezes at the displayed position.
- **EVAL** (1 cycle): compute the overlap.
  - If prev_block_size == 0, the overlap is the whole current block.
  - Otherwise p = prev_block_start >> UNIT_LOG2, pe = p + prev_block_size - 1, ce = pos + size - 1.
  - os = max(pos, p), oe = min(ce, pe). hit = (os ≤ oe).
  - All comparisons are unsigned, 6-bit-safe.
- **COMMIT** (1 cycle): stop_true=1, intersect_true=hit.
  - On hit: curr_* = overlap (start os<<UNIT_LOG2, size oe-os+1), next_size = oe-os+1, level+1. If the new level == MAX_LEVEL, set win and game_over and go to OVER; else go to LOAD.
  - On miss: curr_* hold the frozen block, game_over=1, go to OVER.
- **OVER**: terminal. go is ignored and the curr_* outputs hold. Only resetn exits OVER.

Reset (resetn low at a clock edge), from any state including mid-move or COMMIT:
- State goes to LOAD, next_size = INIT_SIZE.
- pos, tick, level, go_q and all outputs go to 0, including curr_block_start/end/size, stop_true, intersect_true, game_over and win.

## Timing

- Reset release to first visible block: 2 cycles (LOAD executes on the first edge after release).
- go edge sampled on cycle N: EVAL on N+1, and stop_true/intersect_true/curr_* = overlap are all visible during N+2, asserted on the same edge. stop_true is high for exactly one cycle.
- curr_* stay stable from COMMIT through the following LOAD edge. The tracker is transparent during stop_true, so curr_* must never change while stop_true=1.
- A held go produces only one stop; a new edge needs go low for at least one cycle.
- A go edge in LOAD, EVAL, COMMIT or OVER is ignored (go_q still updates).

## Test plan

All scenarios use UNIT_LOG2=4, COLS=20, INIT_SIZE=4, SPEED_DIV=4, MAX_LEVEL=3.

1. **Reset:** hold resetn low 3 cycles → all outputs 0. After release, the 2nd edge gives curr 0/63/4 and level 0.
2. **Bounce:** no go. After 16 moves (64 cycles in MOVE) curr 256/319. The next move gives 240/303. Moves continue down to 0, then back to 16.
3. **First stop:** prev_size=0, go edge at pos 5 → 2 cycles later a single-cycle stop_true=1 with intersect_true=1, curr 80/143/4, level 1. Next block starts at 0/63.
4. **Partial overlap:** prev 80/143/4, go at pos 7 → stop_true with intersect 1, curr 112/143/2. The next LOAD gives 0/31/2.
5. **Miss, then go while held:** prev 80/143/4, go at pos 10 → intersect_true=0, game_over=1, win=0. Later go edges cause no stop_true. A held go during MOVE yields exactly one stop.
6. **Win, and reset mid-move:** three exact stacks give level 3 with win=1 and game_over=1. resetn low while MOVE is at pos 9 → all outputs 0 and the game restarts at size 4.
